// File: rtl/alu_unit.sv
// Handshaked ALU: registered result/flags, accumulator operand, FSM IDLE/DONE(/BUSY).
// Define ALU_MUL_EN to build the WIDTH-cycle shift-add multiplier on op 111.
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zf,
  output logic             ovf,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       dbg_state
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MUL_EN
    , S_BUSY = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_co;
  logic             r_zf;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;

  logic             w_load_alu;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_co;
  logic             w_alu_ovf;
  logic             w_is_sub;
  logic [SW-1:0]    w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;

  // Handshake: a transfer happens on a rising edge where valid && ready; in_ready and
  // out_valid come only from r_state, and a held result never changes until consumed.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign co        = r_co;
  assign zf        = r_zf;
  assign ovf       = r_ovf;
  assign acc       = r_acc;
  assign dbg_state = r_state;

  assign w_op_a   = use_acc ? r_acc : a;
  assign w_sh     = b[SW-1:0];
  assign w_is_sub = (op == OP_SUB);
  assign w_b_eff  = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, w_op_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  // Extra guard bit catches the last bit shifted out; a zero shift leaves it 0.
  assign w_shl    = {1'b0, w_op_a} << w_sh;
  assign w_shr    = {w_op_a, 1'b0} >> w_sh;

  always_comb begin
    w_alu_res = w_op_a;
    w_alu_co  = 1'b0;
    w_alu_ovf = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_co  = w_sum[WIDTH];
        w_alu_ovf = (w_op_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      OP_AND: w_alu_res = w_op_a & b;
      OP_OR:  w_alu_res = w_op_a | b;
      OP_XOR: w_alu_res = w_op_a ^ b;
      OP_SHL: begin
        w_alu_res = w_shl[WIDTH-1:0];
        w_alu_co  = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_alu_res = w_shr[WIDTH:1];
        w_alu_co  = w_shr[0];
      end
      default: w_alu_res = w_op_a;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic               w_start_mul;
  logic               w_load_mul;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_start_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_op_a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if ((r_state == S_BUSY) && (r_cnt != CNT_LAST)) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_alu  = 1'b0;
`ifdef ALU_MUL_EN
    w_start_mul = 1'b0;
    w_load_mul  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            w_start_mul = 1'b1;
            w_state_nxt = S_BUSY;
          end else
`endif
          begin
            w_load_alu  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        if (r_cnt == CNT_LAST) begin
          w_load_mul  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The accumulator tracks every registered result; consuming the output leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_co     <= 1'b0;
      r_zf     <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
    end else if (w_load_alu) begin
      r_result <= w_alu_res;
      r_co     <= w_alu_co;
      r_zf     <= (w_alu_res == '0);
      r_ovf    <= w_alu_ovf;
      r_acc    <= w_alu_res;
    end
`ifdef ALU_MUL_EN
    else if (w_load_mul) begin
      r_result <= r_prod[WIDTH-1:0];
      r_co     <= |r_prod[2*WIDTH-1:WIDTH];
      r_zf     <= (r_prod[WIDTH-1:0] == '0);
      r_ovf    <= 1'b0;
      r_acc    <= r_prod[WIDTH-1:0];
    end
`endif
  end

endmodule
